audio_dac_serializer: RTL

- Codec-side transmit end of the write/write_ready/writedata_left/writedata_right handshake used by the filter datapath.
- Buffers stereo sample pairs written in the CLOCK_50 domain in a small FIFO.
- Serializes each pair onto AUD_DACDAT in left-justified format, timed by the codec-driven AUD_BCLK and AUD_DACLRCK.
- Sits between the filter top level and the WM8731 DAC pins; the codec is bit-clock and LR-clock master.

---
 rtl/audio_dac_serializer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: stereo sample FIFO in the CLOCK_50 domain, drained one
// pair per LR frame onto AUD_DACDAT in left-justified format. The WM8731 is
// the bit-clock and LR-clock master, so AUD_BCLK / AUD_DACLRCK are
// synchronized and edge-detected here, and every action happens on CLOCK_50.
//
// Handshake: write/write_ready follow valid/ready rules. A pair transfers on
// any rising CLOCK_50 edge where write && write_ready. write_ready depends
// only on registered state and never on write. A write while write_ready=0
// is simply not taken, and the source may hold or drop it.
module audio_dac_serializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         writedata_left,
  input  logic [DATA_WIDTH-1:0]         writedata_right,
  output logic                          write_ready,
  input  logic                          clear_underflow,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int PAIR_W = 2 * DATA_WIDTH;

  // Synchronizers, edge registers and the arming shift register
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_prev;
  logic                   lrck_prev;
  logic [SYNC_STAGES:0]   arm_sh;
  logic                   armed;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_fall;
  logic                   lrck_rise;
  logic                   lrck_fall;

  // FIFO storage and pointers
  logic [PAIR_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PAIR_W-1:0]      rd_data;
  logic                   push;
  logic                   pop;

  // Serializer state and its next values
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  hold_reg;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_next;
  logic [DATA_WIDTH-1:0]  hold_next;
  logic [BIT_W-1:0]       bit_next;
  logic                   underflow_set;
  logic                   underflow_next;

  // Synchronize both codec clocks, keep one previous sample, and count the
  // cycles since reset release so edges are trusted only once the whole
  // chain holds real pin values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
      arm_sh    <= '0;
    end else begin
      bclk_sync[0] <= AUD_BCLK;
      lrck_sync[0] <= AUD_DACLRCK;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sync[i] <= bclk_sync[i-1];
        lrck_sync[i] <= lrck_sync[i-1];
      end
      bclk_prev <= bclk_s;
      lrck_prev <= lrck_s;
      arm_sh[0] <= 1'b1;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        arm_sh[i] <= arm_sh[i-1];
      end
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign armed     = arm_sh[SYNC_STAGES];
  assign bclk_fall = armed & ~bclk_s &  bclk_prev;
  assign lrck_rise = armed &  lrck_s & ~lrck_prev;
  assign lrck_fall = armed & ~lrck_s &  lrck_prev;

  assign write_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push        = write & write_ready;
  assign rd_data     = mem[rd_ptr];

  // FIFO storage: the data is written on the push cycle. It is not reset,
  // because clearing the pointers and the count already discards it.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= {writedata_left, writedata_right};
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencing. An LR rise loads left, or zeros on an empty FIFO. An
  // LR fall loads right. Otherwise a BCLK fall shifts. Any LR edge overrides
  // a coincident BCLK fall, so the new word's MSB is not skipped.
  always_comb begin
    shift_next    = shift_reg;
    hold_next     = hold_reg;
    bit_next      = bit_cnt;
    pop           = 1'b0;
    underflow_set = 1'b0;
    if (lrck_rise) begin
      bit_next = '0;
      if (fifo_count != '0) begin
        pop        = 1'b1;
        shift_next = rd_data[PAIR_W-1:DATA_WIDTH];
        hold_next  = rd_data[DATA_WIDTH-1:0];
      end else begin
        shift_next    = '0;
        hold_next     = '0;
        underflow_set = 1'b1;
      end
    end else if (lrck_fall) begin
      shift_next = hold_reg;
      bit_next   = '0;
    end else if (bclk_fall) begin
      if (bit_cnt < BIT_W'(DATA_WIDTH - 1)) begin
        shift_next = shift_reg << 1;
        bit_next   = bit_cnt + BIT_W'(1);
      end else begin
        shift_next = '0;
      end
    end
  end

  // Sticky underflow: a new empty-frame event beats a simultaneous clear
  always_comb begin
    underflow_next = underflow;
    if (underflow_set) begin
      underflow_next = 1'b1;
    end else if (clear_underflow) begin
      underflow_next = 1'b0;
    end
  end

  // Serializer and flag registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      underflow <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      hold_reg  <= hold_next;
      bit_cnt   <= bit_next;
      underflow <= underflow_next;
    end
  end

  // The shift register MSB is already a flop output, so the pin is glitch-free
  assign AUD_DACDAT = shift_reg[DATA_WIDTH-1];

endmodule
